pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline: it drives the write-enable, bubble and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It combines load-use hazard detection, taken-branch/jump flush and a multi-cycle data-memory handshake into one priority-resolved control set. It also keeps stall and flush performance counters and a memory-wait watchdog.

## Interface
- MAX_WAIT, 255: longest allowed MEM_WAIT residency in cycles before `mem_err_o` is set; range 1..255.
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  pipeline clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_Rt_i  in  5  destination register of the load in EX.
- IFID_Rs_i  in  5  rs field of the instruction in ID.
- IFID_Rt_i  in  5  rt field of the instruction in ID.
- Branch_taken_i  in  1  branch resolved taken in ID.
- Jump_i  in  1  jump decoded in ID.
- EXMEM_MemAccess_i  in  1  instruction in MEM reads or writes data memory.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- PC_Write_o  out  1  PC load enable.
- IFID_Write_o  out  1  IF_ID load enable.
- IFID_Flush_o  out  1  IF_ID loads a NOP.
- IDEX_Bubble_o  out  1  ID_EX loads zeroed control (WB=00, M=00, EX=0).
- EXMEM_Hold_o  out  1  EX_MEM keeps its contents.
- MEMWB_Bubble_o  out  1  MEM_WB loads WB=00 (no RegWrite, no MemToReg).
- dmem_req_o  out  1  data-memory request.
- mem_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  cycles with PC_Write_o=0.
- flush_cnt_o  out  CNT_W  cycles with IFID_Flush_o=1.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Memory handshake:
  - `dmem_req_o` = EXMEM_MemAccess_i in RUN, and 1 in MEM_WAIT.
  - In RUN, a request with `dmem_ack_i`=0 moves the FSM to MEM_WAIT.
  - In RUN, a request with ack in the same cycle is zero-wait; the FSM stays in RUN.
  - MEM_WAIT without ack: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0, EXMEM_Hold_o=1, MEMWB_Bubble_o=1. ID_EX holds because its write enable is the same freeze as IF_ID.
  - MEM_WAIT with ack: the pipeline advances as in RUN and the FSM moves to RUN.
- Load-use hazard:
  - Condition: IDEX_MemRead_i=1, IDEX_Rt_i≠0, and IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i.
  - Response: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
  - Lasts one cycle; it is combinational, with no extra state.
- Flush: Branch_taken_i or Jump_i gives IFID_Flush_o=1, with PC_Write_o=1.
- Priority, highest first: reset, memory freeze, load-use, flush.
  - A branch in ID during a load-use stall is not flushed; it is re-evaluated next cycle.
- Default (no event): PC_Write_o=1, IFID_Write_o=1, every bubble/hold/flush output 0.
- Watchdog:
  - An 8-bit wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When it reaches MAX_WAIT, mem_err_o is set; it stays set until rst_i.
  - The FSM keeps waiting after the error.
- Counters: saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from the state and inputs; they take effect on the edge ending the current cycle.
- Load-use stall is exactly 1 cycle. The dependent instruction issues to EX one cycle after the load leaves EX.
- Memory stall is N cycles for an ack arriving N cycles after first request; zero-wait means 0 stall cycles.
- Flush costs 1 bubble in IF_ID.
- While rst_i=1:
  - PC_Write_o=0, IFID_Write_o=0.
  - IFID_Flush_o=1, IDEX_Bubble_o=1, MEMWB_Bubble_o=1.
  - EXMEM_Hold_o=0, dmem_req_o=0.
- After the reset edge: state=RUN, counters=0, wait counter=0, mem_err_o=0.
- Reset during MEM_WAIT: dmem_req_o drops in the same cycle and the FSM is in RUN after the edge. A pending ack is ignored.
- Ack arriving while EXMEM_MemAccess_i=0 in RUN: ignored.

## Structure
- Package pipe_ctrl_pkg holds:
  - state encoding (RUN=0, MEM_WAIT=1);
  - REG_ZERO=5'd0;
  - the bubble control constants WB_NOP=2'b00 and M_NOP=2'b00.
- One sub-module, hazard_detect: the combinational load-use comparator, output `lu_stall`.

## Test plan
- Load-use: lw $2 in EX, ID has rs=2 → one cycle with PC_Write_o=0 and IDEX_Bubble_o=1; stall_cnt_o=1; next cycle defaults. Repeat with IDEX_Rt_i=0 → no stall.
- Taken branch with no hazard → IFID_Flush_o=1 and PC_Write_o=1 for one cycle; flush_cnt_o increments.
- Memory access with ack 3 cycles after first request → 3 cycles with EXMEM_Hold_o=1 and MEMWB_Bubble_o=1, then advance in the ack cycle; stall_cnt_o=3. Zero-wait ack → no stall.
- MAX_WAIT=4, ack withheld → mem_err_o rises after 4 MEM_WAIT cycles and stays set after a late ack; clears only on rst_i.
- Simultaneous memory wait, load-use and branch → freeze outputs only, no flush. After the ack, load-use wins over the branch.
- rst_i asserted mid-MEM_WAIT → dmem_req_o=0 that cycle; after the edge, RUN with all counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Zeroed control fields loaded by ID_EX / MEM_WB when a bubble is inserted.
  localparam logic [1:0] WB_NOP = 2'b00;
  localparam logic [1:0] M_NOP  = 2'b00;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu_stall
);

  // $zero never carries a real dependence.
  assign lu_stall = mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Priority-resolved stall/flush control for the 5-stage pipeline, with a data-memory
// wait FSM, memory-wait watchdog and saturating stall/flush counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             EXMEM_MemAccess_i,
  input  logic             dmem_ack_i,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             EXMEM_Hold_o,
  output logic             MEMWB_Bubble_o,
  output logic             dmem_req_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t             state_reg, state_next;
  logic [7:0]         wait_cnt_reg, wait_cnt_next;
  logic               mem_err_reg, mem_err_next;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
  logic               lu_stall;
  logic               req_raw;
  logic               mem_freeze;

  hazard_detect u_hazard_detect (
    .mem_read (IDEX_MemRead_i),
    .ex_rt    (IDEX_Rt_i),
    .id_rs    (IFID_Rs_i),
    .id_rt    (IFID_Rt_i),
    .lu_stall (lu_stall)
  );

  // An outstanding request without ack freezes the pipe, including the first RUN cycle.
  assign req_raw    = (state_reg == MEM_WAIT) || EXMEM_MemAccess_i;
  assign mem_freeze = req_raw && !dmem_ack_i;

  always_comb begin
    state_next     = state_reg;
    PC_Write_o     = 1'b1;
    IFID_Write_o   = 1'b1;
    IFID_Flush_o   = 1'b0;
    IDEX_Bubble_o  = 1'b0;
    EXMEM_Hold_o   = 1'b0;
    MEMWB_Bubble_o = 1'b0;
    dmem_req_o     = req_raw;
    if (rst_i) begin
      state_next     = RUN;
      PC_Write_o     = 1'b0;
      IFID_Write_o   = 1'b0;
      IFID_Flush_o   = 1'b1;
      IDEX_Bubble_o  = 1'b1;
      MEMWB_Bubble_o = 1'b1;
      dmem_req_o     = 1'b0;
    end else if (mem_freeze) begin
      state_next     = MEM_WAIT;
      PC_Write_o     = 1'b0;
      IFID_Write_o   = 1'b0;
      EXMEM_Hold_o   = 1'b1;
      MEMWB_Bubble_o = 1'b1;
    end else begin
      state_next = RUN;
      if (lu_stall) begin
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end else if (Branch_taken_i || Jump_i) begin
        IFID_Flush_o = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    if (state_reg == RUN && state_next == MEM_WAIT) begin
      wait_cnt_next = 8'd0;
    end else if (state_reg == MEM_WAIT) begin
      if (wait_cnt_reg != 8'hFF)
        wait_cnt_next = wait_cnt_reg + 8'd1;
      if (({1'b0, wait_cnt_reg} + 9'd1) >= 9'(MAX_WAIT))
        mem_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 8'd0;
      mem_err_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
      if (!PC_Write_o && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (IFID_Flush_o && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign mem_err_o   = mem_err_reg;
  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; control outputs are compared as one packed vector
// {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Hold, MEMWB_Bubble, dmem_req}.
module tb_pipeline_ctrl;

  localparam int CNT_W = 16;

  localparam logic [6:0] C_DEF   = 7'b1100000;
  localparam logic [6:0] C_ADV   = 7'b1100001;
  localparam logic [6:0] C_RST   = 7'b0011010;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_FLUSH = 7'b1110000;
  localparam logic [6:0] C_FRZ   = 7'b0000111;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, br, jmp, mem_acc, ack;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_w, ifid_w, ifid_fl, idex_bub, exmem_hold, memwb_bub, req, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .IDEX_MemRead_i    (mem_read),
    .IDEX_Rt_i         (ex_rt),
    .IFID_Rs_i         (id_rs),
    .IFID_Rt_i         (id_rt),
    .Branch_taken_i    (br),
    .Jump_i            (jmp),
    .EXMEM_MemAccess_i (mem_acc),
    .dmem_ack_i        (ack),
    .PC_Write_o        (pc_w),
    .IFID_Write_o      (ifid_w),
    .IFID_Flush_o      (ifid_fl),
    .IDEX_Bubble_o     (idex_bub),
    .EXMEM_Hold_o      (exmem_hold),
    .MEMWB_Bubble_o    (memwb_bub),
    .dmem_req_o        (req),
    .mem_err_o         (err),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  assign ctl = {pc_w, ifid_w, ifid_fl, idex_bub, exmem_hold, memwb_bub, req};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 0; br = 0; jmp = 0; mem_acc = 0; ack = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_acc = 1;
    #2;
    checks++;
    if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_RST); end
    $display("reset: ctl=%b", ctl);
    tick(); tick();
    rst = 0; mem_acc = 0;
    #1;
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL reset_default got=%b want=%b", ctl, C_DEF); end
    checks++;
    if ({err, stall_cnt, flush_cnt} !== {1'b0, 16'd0, 16'd0}) begin
      errors++; $display("FAIL reset_state err=%b stall=%0d flush=%0d want 0/0/0", err, stall_cnt, flush_cnt);
    end
    $display("post-reset: ctl=%b err=%b stall=%0d flush=%0d", ctl, err, stall_cnt, flush_cnt);
  endtask

  task automatic test_load_use();
    mem_read = 1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd5;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs_ctl got=%b want=%b", ctl, C_LU); end
    tick();
    mem_read = 0;
    #1;
    checks++;
    if (ctl !== C_DEF || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_after got=%b stall=%0d want=%b stall=1", ctl, stall_cnt, C_DEF);
    end
    $display("load-use rs: stall_cnt=%0d", stall_cnt);
    tick();
    mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL lu_zero got=%b want=%b", ctl, C_DEF); end
    tick();
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt_ctl got=%b want=%b", ctl, C_LU); end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_rt_cnt got=%0d want=2", stall_cnt); end
    $display("load-use rt: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_flush();
    br = 1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_ctl got=%b want=%b", ctl, C_FLUSH); end
    tick();
    br = 0; jmp = 1;
    #1;
    checks++;
    if (ctl !== C_FLUSH || flush_cnt !== 16'd1) begin
      errors++; $display("FAIL jmp_ctl got=%b flush=%0d want=%b flush=1", ctl, flush_cnt, C_FLUSH);
    end
    tick();
    jmp = 0;
    #1;
    checks++;
    if (ctl !== C_DEF || flush_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_after got=%b flush=%0d want=%b flush=2", ctl, flush_cnt, C_DEF);
    end
    $display("flush: flush_cnt=%0d", flush_cnt);
  endtask

  task automatic test_mem_wait();
    mem_acc = 1; ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_FRZ) begin errors++; $display("FAIL mem_freeze%0d got=%b want=%b", i, ctl, C_FRZ); end
      tick();
    end
    ack = 1;
    #1;
    checks++;
    if (ctl !== C_ADV) begin errors++; $display("FAIL mem_ack got=%b want=%b", ctl, C_ADV); end
    tick();
    mem_acc = 0; ack = 0;
    #1;
    checks++;
    if (ctl !== C_DEF || stall_cnt !== 16'd5 || err !== 1'b0) begin
      errors++; $display("FAIL mem_after got=%b stall=%0d err=%b want=%b stall=5 err=0", ctl, stall_cnt, err, C_DEF);
    end
    $display("mem wait 3: stall_cnt=%0d", stall_cnt);
    mem_acc = 1; ack = 1;
    #1;
    checks++;
    if (ctl !== C_ADV) begin errors++; $display("FAIL mem_zero got=%b want=%b", ctl, C_ADV); end
    tick();
    mem_acc = 0;
    #1;
    checks++;
    if (ctl !== C_DEF || stall_cnt !== 16'd5) begin
      errors++; $display("FAIL stray_ack got=%b stall=%0d want=%b stall=5", ctl, stall_cnt, C_DEF);
    end
    tick();
    ack = 0;
    $display("zero-wait: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_simultaneous();
    mem_acc = 1; ack = 0; mem_read = 1; ex_rt = 5'd4; id_rs = 5'd4; br = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_FRZ) begin errors++; $display("FAIL simul_freeze%0d got=%b want=%b", i, ctl, C_FRZ); end
      tick();
    end
    ack = 1;
    #1;
    checks++;
    if (ctl !== 7'b0001001) begin errors++; $display("FAIL simul_lu got=%b want=%b", ctl, 7'b0001001); end
    tick();
    mem_acc = 0; ack = 0; mem_read = 0;
    #1;
    checks++;
    if (ctl !== C_FLUSH || stall_cnt !== 16'd8 || flush_cnt !== 16'd2) begin
      errors++; $display("FAIL simul_branch got=%b stall=%0d flush=%0d want=%b stall=8 flush=2", ctl, stall_cnt, flush_cnt, C_FLUSH);
    end
    tick();
    clear_inputs();
    $display("simultaneous: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
  endtask

  task automatic test_watchdog();
    mem_acc = 1; ack = 0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (err !== (i >= 4)) begin errors++; $display("FAIL wd_cycle%0d err=%b want=%b", i, err, (i >= 4)); end
    end
    mem_acc = 0;
    #1;
    checks++;
    if (ctl !== C_FRZ) begin errors++; $display("FAIL wd_still_wait got=%b want=%b", ctl, C_FRZ); end
    ack = 1;
    tick();
    ack = 0;
    #1;
    checks++;
    if (err !== 1'b1 || ctl !== C_DEF || stall_cnt !== 16'd13) begin
      errors++; $display("FAIL wd_sticky err=%b ctl=%b stall=%0d want err=1 ctl=%b stall=13", err, ctl, stall_cnt, C_DEF);
    end
    $display("watchdog: err=%b stall_cnt=%0d", err, stall_cnt);
  endtask

  task automatic test_reset_mid_wait();
    mem_acc = 1; ack = 0;
    tick(); tick();
    rst = 1; ack = 1;
    #1;
    checks++;
    if (ctl !== C_RST) begin errors++; $display("FAIL rst_wait_ctl got=%b want=%b", ctl, C_RST); end
    tick();
    rst = 0; mem_acc = 0; ack = 0;
    #1;
    checks++;
    if ({ctl, err, stall_cnt, flush_cnt} !== {C_DEF, 1'b0, 16'd0, 16'd0}) begin
      errors++; $display("FAIL rst_wait_after ctl=%b err=%b stall=%0d flush=%0d want %b/0/0/0", ctl, err, stall_cnt, flush_cnt, C_DEF);
    end
    $display("reset mid-wait: ctl=%b err=%b stall=%0d flush=%0d", ctl, err, stall_cnt, flush_cnt);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_mem_wait();
    test_simultaneous();
    test_watchdog();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
